// File: rtl/nv_nvdla_sdp_core_y_dpgather.sv
// rtl/nv_nvdla_sdp_core_y_dpgather.sv - SDP Y-path narrow-to-wide beat gatherer (RATIO x IN_W -> OUT_W)
// Optional feature macro: NV_NVDLA_SDP_Y_GATHER_PERF_EN adds out_stall_cnt.
module nv_nvdla_sdp_core_y_dpgather #(
  parameter int IN_W  = 128,
  parameter int RATIO = 4
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   inp_pvld,
  input  logic [IN_W-1:0]        inp_data,
  input  logic                   inp_last,
  output logic                   inp_prdy,
  output logic                   out_pvld,
  output logic [IN_W*RATIO-1:0]  out_data,
  output logic [RATIO-1:0]       out_mask,
  input  logic                   out_prdy
`ifdef NV_NVDLA_SDP_Y_GATHER_PERF_EN
  ,
  output logic [31:0]            out_stall_cnt
`endif
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);

  // accumulator state: partial (or held complete) word being gathered
  logic [CW-1:0]    acc_cnt;
  logic             acc_full;
  logic [RATIO-1:0] acc_mask;
  logic [OUT_W-1:0] acc_data;

  logic             out_free;
  logic             inp_acc;
  logic             beat_done;
  logic             acc_drain;
  logic             word_direct;
  logic             out_load;
  logic [RATIO-1:0] seg_sel;
  logic [OUT_W-1:0] base_data;
  logic [RATIO-1:0] base_mask;
  logic [OUT_W-1:0] merged_data;
  logic [RATIO-1:0] merged_mask;
  logic [OUT_W-1:0] load_data;
  logic [RATIO-1:0] load_mask;

  // handshake and word-completion control
  always_comb begin
    out_free    = !out_pvld | out_prdy;
    inp_prdy    = !acc_full | out_free;
    inp_acc     = inp_pvld & inp_prdy;
    beat_done   = inp_acc & ((acc_cnt == CW'(RATIO - 1)) | inp_last);
    // a held word leaves for the output as soon as the output frees up
    acc_drain   = acc_full & out_free;
    // a completing beat bypasses the accumulator only if nothing is held ahead of it
    word_direct = beat_done & out_free & !acc_full;
    out_load    = acc_drain | word_direct;
  end

  // one-hot segment decode of the write pointer; unmatched counts select nothing
  always_comb begin
    seg_sel = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (acc_cnt == CW'(i)) seg_sel[i] = 1'b1;
    end
  end

  // merge the current beat into the accumulator (emptied first when the held word drains)
  always_comb begin
    base_data = acc_drain ? '0 : acc_data;
    base_mask = acc_drain ? '0 : acc_mask;
    merged_data = base_data;
    merged_mask = base_mask;
    for (int i = 0; i < RATIO; i++) begin
      if (inp_acc & seg_sel[i]) begin
        merged_data[i*IN_W +: IN_W] = inp_data;
        merged_mask[i]              = 1'b1;
      end
    end
    load_data = acc_drain ? acc_data : merged_data;
    load_mask = acc_drain ? acc_mask : merged_mask;
  end

  // accumulator update: segment pointer, gathered data, and held-word flag
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      acc_cnt  <= '0;
      acc_full <= 1'b0;
      acc_mask <= '0;
      acc_data <= '0;
    end else begin
      if (beat_done) begin
        acc_cnt <= '0;
      end else if (inp_acc) begin
        acc_cnt <= acc_cnt + 1'b1;
      end

      if (word_direct) begin
        // word went straight to the output; start the next one empty
        acc_data <= '0;
        acc_mask <= '0;
        acc_full <= 1'b0;
      end else if (beat_done) begin
        // output busy (or just refilled by the drain): hold the finished word here
        acc_data <= merged_data;
        acc_mask <= merged_mask;
        acc_full <= 1'b1;
      end else if (inp_acc | acc_drain) begin
        acc_data <= merged_data;
        acc_mask <= merged_mask;
        acc_full <= 1'b0;
      end
    end
  end

  // output register: load a finished word, or retire the current one on out_prdy
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      out_pvld <= 1'b0;
      out_mask <= '0;
      out_data <= '0;
    end else if (out_load) begin
      out_pvld <= 1'b1;
      out_mask <= load_mask;
      out_data <= load_data;
    end else if (out_prdy) begin
      // data is left as-is when the word retires; only valid and mask drop
      out_pvld <= 1'b0;
      out_mask <= '0;
    end
  end

`ifdef NV_NVDLA_SDP_Y_GATHER_PERF_EN
  // saturating count of cycles the output is stalled by the consumer
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      out_stall_cnt <= '0;
    end else if (out_pvld & !out_prdy & (out_stall_cnt != 32'hFFFF_FFFF)) begin
      out_stall_cnt <= out_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_core_y_dpgather.sv
// tb/tb_nv_nvdla_sdp_core_y_dpgather.sv - self-checking bench for the SDP Y-path beat gatherer
module tb_nv_nvdla_sdp_core_y_dpgather;

  localparam int IN_W  = 128;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic               nvdla_core_clk;
  logic               nvdla_core_rstn;
  logic               inp_pvld;
  logic [IN_W-1:0]    inp_data;
  logic               inp_last;
  logic               inp_prdy;
  logic               out_pvld;
  logic [OUT_W-1:0]   out_data;
  logic [RATIO-1:0]   out_mask;
  logic               out_prdy;
`ifdef NV_NVDLA_SDP_Y_GATHER_PERF_EN
  logic [31:0]        out_stall_cnt;
`endif

  nv_nvdla_sdp_core_y_dpgather #(.IN_W(IN_W), .RATIO(RATIO)) u_dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .inp_pvld        (inp_pvld),
    .inp_data        (inp_data),
    .inp_last        (inp_last),
    .inp_prdy        (inp_prdy),
    .out_pvld        (out_pvld),
    .out_data        (out_data),
    .out_mask        (out_mask),
    .out_prdy        (out_prdy)
`ifdef NV_NVDLA_SDP_Y_GATHER_PERF_EN
    ,
    .out_stall_cnt   (out_stall_cnt)
`endif
  );

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int checks;
  int errors;

  // reference model: beats gathered so far, and finished words awaiting the consumer (FIFO order)
  logic [IN_W-1:0]  part_q[$];
  logic [OUT_W-1:0] exp_d[$];
  logic [RATIO-1:0] exp_m[$];
  longint           exp_stall;
  bit               after_reset;

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    exp_d.delete();
    exp_m.delete();
    exp_stall   = 0;
    after_reset = 1'b1;
  endtask

  // one clock of stimulus: drive, check against the model, advance the model
  task automatic cycle(input bit pv, input logic [IN_W-1:0] d, input bit last, input bit pr);
    bit               e_pvld;
    bit               e_prdy;
    logic [OUT_W-1:0] w;
    logic [RATIO-1:0] m;
    @(negedge nvdla_core_clk);
    inp_pvld = pv;
    inp_data = d;
    inp_last = last;
    out_prdy = pr;
    #1;
    // the block holds at most one word on the output and one finished word behind it
    e_pvld = (exp_d.size() != 0);
    e_prdy = !((exp_d.size() == 2) && !pr);
    check("out_pvld", OUT_W'(out_pvld), OUT_W'(e_pvld));
    check("inp_prdy", OUT_W'(inp_prdy), OUT_W'(e_prdy));
    if (after_reset) begin
      check("reset_out_data", out_data, '0);
      after_reset = 1'b0;
    end
    if (e_pvld) begin
      check("out_data", out_data, exp_d[0]);
      check("out_mask", OUT_W'(out_mask), OUT_W'(exp_m[0]));
    end else begin
      check("idle_out_mask", OUT_W'(out_mask), '0);
    end
`ifdef NV_NVDLA_SDP_Y_GATHER_PERF_EN
    check("out_stall_cnt", OUT_W'(out_stall_cnt), OUT_W'(exp_stall));
`endif
    if (e_pvld && pr) begin
      void'(exp_d.pop_front());
      void'(exp_m.pop_front());
    end
    if (e_pvld && !pr && exp_stall < 64'hFFFF_FFFF) exp_stall++;
    if (pv && e_prdy) begin
      part_q.push_back(d);
      if (last || part_q.size() == RATIO) begin
        w = '0;
        m = '0;
        foreach (part_q[i]) begin
          w[i*IN_W +: IN_W] = part_q[i];
          m[i]              = 1'b1;
        end
        exp_d.push_back(w);
        exp_m.push_back(m);
        part_q.delete();
      end
    end
    @(posedge nvdla_core_clk);
  endtask

  task automatic do_reset();
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b0;
    inp_pvld        = 1'b0;
    inp_last        = 1'b0;
    out_prdy        = 1'b0;
    @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;
    model_reset();
  endtask

  function automatic logic [IN_W-1:0] rnd_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    checks          = 0;
    errors          = 0;
    nvdla_core_rstn = 1'b0;
    inp_pvld        = 1'b0;
    inp_data        = '0;
    inp_last        = 1'b0;
    out_prdy        = 1'b0;
    repeat (2) @(posedge nvdla_core_clk);
    do_reset();

    // full-rate word 01..04, then drain
    for (int i = 1; i <= 4; i++) cycle(1'b1, IN_W'(i), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // partial word A,B closed by inp_last; next beat C starts at segment 0
    cycle(1'b1, IN_W'(128'hA), 1'b0, 1'b1);
    cycle(1'b1, IN_W'(128'hB), 1'b1, 1'b1);
    cycle(1'b1, IN_W'(128'hC), 1'b1, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);

    // backpressure: 8 beats with consumer stalled, then release
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, IN_W'(i + 16), 1'b0, 1'b0);
    cycle(1'b1, IN_W'(128'h99), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);

    // output stability over a 5-cycle stall
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, rnd_beat(), 1'b0, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);

    // reset mid-word, then a clean full word
    cycle(1'b1, rnd_beat(), 1'b0, 1'b1);
    cycle(1'b1, rnd_beat(), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_beat(), 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);

    // back-to-back single-beat words
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_beat(), 1'b1, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);

    // randomized traffic with random consumer stalls
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 3) != 0), rnd_beat(), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 6));
    end
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_sdp_core_y_dpgather.md
Name: nv_nvdla_sdp_core_y_dpgather

Overview:
Narrow-to-wide packer for the SDP Y-path. It gathers RATIO consecutive IN_W-bit beats into one OUT_W-bit word: 4x128 into 512 by default. It is the inverse of the Y-path 512-to-128 segment splitter and sits on the return side, where narrow per-cycle results are reassembled into full atom width before write-out. An early-terminate flag (inp_last) closes a partial word and zero-fills the rest, with a valid-segment mask.

Parameters:
IN_W, 128, width of one input beat/segment.
RATIO, 4, beats per output word; power of two, 2..8.
OUT_W (localparam), IN_W*RATIO, output word width.

Ports:
nvdla_core_clk  input  1  core clock.
nvdla_core_rstn  input  1  synchronous active-low reset, sampled on rising nvdla_core_clk.
inp_pvld  input  1  input beat valid.
inp_data  input  IN_W  input beat.
inp_last  input  1  beat closes the current word, even if partial.
inp_prdy  output  1  input ready.
out_pvld  output  1  output word valid.
out_data  output  OUT_W  packed word; segment i occupies [IN_W*i+IN_W-1 : IN_W*i].
out_mask  output  RATIO  bit i = segment i holds real data.
out_prdy  input  1  output ready.

Behaviour:
- One clock. Reset is synchronous and active-low; all state updates on rising nvdla_core_clk.
- Reset state:
  - acc_cnt=0, acc_full=0, acc_mask=0.
  - out_pvld=0, out_mask=0, out_data=0.
  - Reset mid-word discards the partial word and any held word.
- Accept condition: inp_acc = inp_pvld & inp_prdy. An accepted beat writes segment acc_cnt and sets acc_mask[acc_cnt].
- Completing beat: an accepted beat with acc_cnt==RATIO-1 or inp_last==1.
  - On a completing beat, acc_cnt returns to 0.
  - On any other accepted beat, acc_cnt increments.
- Segment order: the first beat lands in segment 0 (LSBs).
- Partial words: unwritten segments are driven 0 and their mask bits are 0.
- Output register load, out_free = !out_pvld | out_prdy:
  - Completing beat with out_free: the word (previous segments plus the current beat) loads straight into the output register. out_pvld=1 the next cycle, i.e. latency 1 cycle from the final beat.
  - Completing beat with !out_free: the word stays in the accumulator and acc_full=1.
  - While acc_full=1: inp_prdy=0. When out_free becomes true, the word loads into the output register and acc_full clears. inp_prdy is 1 in that same cycle, so a new beat may be accepted into segment 0 concurrently.
- inp_prdy = !acc_full | out_free.
- Output handshake:
  - out_pvld/out_data/out_mask hold stable while out_pvld & !out_prdy.
  - On out_prdy with nothing to load, out_pvld drops and out_mask clears; out_data keeps its last value.
- Throughput: with out_prdy held 1, the block sustains one beat per cycle and one word per RATIO cycles with no bubbles.
- Boundary cases:
  - inp_last on the first beat: out_mask = 1 in bit 0, rest 0 (0001 for RATIO=4).
  - inp_last on beat RATIO-1: behaves as a normal full word, mask all ones.
  - inp_pvld low between beats: acc_cnt holds; no timeout.
  - Back-to-back inp_last beats: each produces a 1-segment word.
- No X on control: the default branch of the segment decode drives 0.

Optional Feature:
NV_NVDLA_SDP_Y_GATHER_PERF_EN
- Defined: adds output port out_stall_cnt [31:0].
  - Increments each cycle out_pvld & !out_prdy.
  - Saturates at 32'hFFFFFFFF and is cleared only by reset (0 at reset).
- Undefined: the port and counter are absent; functionality is otherwise identical.

Test Plan:
- Full-rate, out_prdy=1: beats 0x..01,0x..02,0x..03,0x..04 on 4 consecutive cycles -> out_pvld the cycle after beat 4; out_data={04,03,02,01} (seg0=01); out_mask=4'b1111; inp_prdy=1 throughout.
- Partial word: beats A,B with inp_last on B -> out_data={0,0,B,A}, out_mask=4'b0011; the next beat C lands in segment 0.
- Backpressure: out_prdy=0, send 8 beats -> word1 held on output, word2 held in accumulator, inp_prdy=0 after the 8th beat. Raise out_prdy -> word1 then word2 emitted on consecutive cycles, inp_prdy returns to 1 the same cycle word2 moves to the output.
- Output stability: out_prdy=0 for 5 cycles with out_pvld=1 -> out_data/out_mask unchanged each cycle. With PERF_EN, out_stall_cnt=5.
- Reset mid-word: 2 beats accepted, nvdla_core_rstn=0 for 1 cycle -> out_pvld=0, out_mask=0. The next 4 beats form a clean full word with mask 1111.
- Single-beat words: 3 consecutive beats each with inp_last=1, out_prdy=1 -> 3 words, each out_mask=4'b0001, one per cycle.
